sha256_padder: RTL
==================

# sha256_padder

Byte-stream front end of the SHA-256 datapath: accepts message bytes, packs them big-endian into 512-bit blocks, and applies FIPS 180-4 padding (0x80, zeros, 64-bit bit-length). Each finished block is streamed as 16 consecutive 32-bit words on the data and handshake lines the message scheduler consumes (`data_in`, `i_padding_done`, `i_flag_0_15`). After the 16 words it waits for the compression core to acknowledge before sending the next block.

## Interface
- `LEN_W`, default 64: width of the message bit-length counter. Values below 64 are zero-extended into the length field.
- `i_clk`  in  1: clock; all state changes on the rising edge.
- `i_rst`  in  1: reset, asynchronous, active-low.
- `i_byte`  in  8: message byte.
- `i_byte_valid`  in  1: `i_byte` is valid.
- `i_byte_last`  in  1: the current byte is the final byte of the message.
- `i_msg_empty`  in  1: one-cycle pulse in IDLE that starts padding of a zero-length message.
- `o_byte_ready`  out  1: byte accepted when `i_byte_valid && o_byte_ready`.
- `o_data`  out  32: block word; connects to the scheduler's `data_in`.
- `o_padding_done`  out  1: a block is being delivered; connects to the scheduler's `i_padding_done`.
- `o_flag_0_15`  out  1: 0 while words 0..15 stream, 1 afterwards; connects to the scheduler's `i_flag_0_15`.
- `o_word_idx`  out  4: index of the word currently on `o_data`.
- `o_block_last`  out  1: the current block is the message's final block.
- `i_block_ack`  in  1: pulse from the core; all 64 rounds of the current block are done.

## Operation
- Storage: a 16×32 block buffer, byte pointer `bp[5:0]`, bit counter `len[LEN_W-1:0]`, and a flag `pend80` meaning "0x80 still owed".
- **IDLE**
  - `o_byte_ready`=1.
  - An accepted byte is written at `bp`, `len+=8`, then go to FILL.
  - `i_msg_empty` forces n=0 and goes to PAD.
- **FILL**
  - `o_byte_ready`=1. Byte k of the block goes to word k/4, bits [31-8*(k%4) -: 8].
  - Accepted byte with `i_byte_last` goes to PAD with n = byte count in the block (1..64).
  - Accepted byte at `bp`=63 without last goes to EMIT, `o_block_last`=0.
- **PAD** (one cycle, `o_byte_ready`=0)
  - n<64: byte n = 0x80, bytes n+1..63 = 0.
  - n≤55: bytes 56..63 = `len` big-endian, `o_block_last`=1.
  - 56≤n<64: set `needlen`, `o_block_last`=0.
  - n=64: set `pend80` and `needlen`, `o_block_last`=0.
  - Always go to EMIT.
- **EMIT** (16 cycles)
  - `o_padding_done`=1, `o_flag_0_15`=0.
  - `o_data`=buffer[`o_word_idx`], with `o_word_idx` counting 0..15.
  - After word 15, go to WAIT_ACK.
- **WAIT_ACK**
  - `o_padding_done`=1, `o_flag_0_15`=1, `o_data` holds word 15.
  - `i_block_ack` goes to GAP.
- **GAP** (exactly one cycle)
  - `o_padding_done`=0 so the scheduler restarts its count.
  - If `needlen`: build the extra block (byte 0 = 0x80 if `pend80`, else 0; zeros; `len` at bytes 56..63), set `o_block_last`=1, clear the flags, go to EMIT.
  - Else if `o_block_last`: clear `len`, go to IDLE.
  - Else: go to FILL with `bp`=0.
- `i_byte_valid` while `o_byte_ready`=0 is ignored; the source holds the byte.
- `i_block_ack` outside WAIT_ACK is ignored.
- `i_msg_empty` outside IDLE is ignored.
- `len` wraps modulo 2^LEN_W; no error is flagged.

## Timing
- Reset values: `o_byte_ready`=0 during reset, then 1 in IDLE. `o_data`=0, `o_padding_done`=0, `o_flag_0_15`=0, `o_word_idx`=0, `o_block_last`=0. All outputs are registered.
- Last byte accepted at cycle t: PAD at t+1, word 0 at t+2, word 15 at t+17, `o_flag_0_15` rises at t+18.
- A full 64-byte block (no last) goes from FILL straight to EMIT: word 0 appears the cycle after the 64th byte.
- `i_block_ack` at cycle a: GAP at a+1, next EMIT word 0 at a+2, or `o_byte_ready`=1 at a+2.
- Asserting `i_rst` at any point, including mid-EMIT, immediately returns to IDLE. The buffer contents are don't-care.

## Configuration
- `SHA256_PADDER_STATUS_EN` defined:
  - Adds output `o_block_cnt[15:0]`, blocks emitted since reset. It increments at the GAP entry and wraps at 0xFFFF→0.
  - Adds output `o_busy`, high in every state except IDLE.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

## Test plan
- "abc" (0x61,0x62,0x63, last) -> one block: word0=0x61626380, words1..14=0, word15=0x00000018, `o_block_last`=1.
- `i_msg_empty` pulse -> word0=0x80000000, other words 0, word15=0x00000000, `o_block_last`=1.
- 55 bytes of 0x61 -> single block: word13=0x61616180, word14=0, word15=0x000001B8.
- 56 bytes of 0x61 -> block 1 word14=0x80000000, word15=0, `o_block_last`=0. After ack and a 1-cycle `o_padding_done` low, block 2 words0..14=0, word15=0x000001C0, `o_block_last`=1.
- 64 bytes -> block 1 holds data only. Block 2: word0=0x80000000, word15=0x00000200.
- Reset asserted at `o_word_idx`=7 -> all outputs reach reset values asynchronously. A following "abc" message produces the exact first-test result.

Source files
------------

// File: rtl/sha256_padder_if.sv
// sha256_padder byte-in / word-out handshake bundle.
// master drives message bytes and block acks; slave is the padder.
interface sha256_padder_if;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        i_byte_last;
  logic        i_msg_empty;
  logic        i_block_ack;
  logic        o_byte_ready;
  logic [31:0] o_data;
  logic        o_padding_done;
  logic        o_flag_0_15;
  logic [3:0]  o_word_idx;
  logic        o_block_last;

  modport master (
    output i_byte, i_byte_valid, i_byte_last,
    output i_msg_empty, i_block_ack,
    input  o_byte_ready, o_data, o_padding_done,
    input  o_flag_0_15, o_word_idx, o_block_last
  );

  modport slave (
    input  i_byte, i_byte_valid, i_byte_last,
    input  i_msg_empty, i_block_ack,
    output o_byte_ready, o_data, o_padding_done,
    output o_flag_0_15, o_word_idx, o_block_last
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 byte packer and FIPS 180-4 padder feeding the scheduler.
// Optional SHA256_PADDER_STATUS_EN adds o_block_cnt and o_busy.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  sha256_padder_if.slave bus
`ifdef SHA256_PADDER_STATUS_EN
  ,
  output logic [15:0] o_block_cnt,
  output logic        o_busy
`endif
);

  typedef enum logic [2:0] {
    IDLE, FILL, PAD, EMIT, WAIT_ACK, GAP
  } st_t;

  st_t              st;
  logic [511:0]     blk;
  logic [511:0]     blk_n;
  logic [5:0]       bp;
  logic [6:0]       n;
  logic [LEN_W-1:0] len;
  logic [63:0]      len64;
  logic             pend80;
  logic             needlen;
  logic             acc;

  assign len64 = 64'(len);
  assign acc = bus.i_byte_valid && bus.o_byte_ready;

  // Next block image; o_data is loaded from it so word 0
  // already carries the padding written on the same edge.
  always_comb begin
    blk_n = blk;
    case (st)
      IDLE, FILL: begin
        if (acc)
          blk_n[511 - 8*int'(bp) -: 8] = bus.i_byte;
      end
      PAD: begin
        for (int k = 0; k < 64; k++) begin
          if (k == int'(n))
            blk_n[511 - 8*k -: 8] = 8'h80;
          else if (k > int'(n))
            blk_n[511 - 8*k -: 8] = 8'h00;
        end
        if (n <= 7'd55)
          blk_n[63:0] = len64;
      end
      GAP: begin
        if (needlen)
          blk_n = {pend80 ? 8'h80 : 8'h00, 440'd0, len64};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      st                 <= IDLE;
      blk                <= '0;
      bp                 <= '0;
      n                  <= '0;
      len                <= '0;
      pend80             <= 1'b0;
      needlen            <= 1'b0;
      bus.o_byte_ready   <= 1'b0;
      bus.o_data         <= '0;
      bus.o_padding_done <= 1'b0;
      bus.o_flag_0_15    <= 1'b0;
      bus.o_word_idx     <= '0;
      bus.o_block_last   <= 1'b0;
`ifdef SHA256_PADDER_STATUS_EN
      o_block_cnt        <= '0;
      o_busy             <= 1'b0;
`endif
    end else begin
      blk <= blk_n;
      case (st)
        IDLE: begin
          bus.o_byte_ready <= 1'b1;
          if (acc) begin
            bp  <= bp + 6'd1;
            len <= len + LEN_W'(8);
`ifdef SHA256_PADDER_STATUS_EN
            o_busy <= 1'b1;
`endif
            if (bus.i_byte_last) begin
              n                <= 7'd1;
              st               <= PAD;
              bus.o_byte_ready <= 1'b0;
            end else begin
              st <= FILL;
            end
          end else if (bus.i_msg_empty) begin
            n                <= 7'd0;
            st               <= PAD;
            bus.o_byte_ready <= 1'b0;
`ifdef SHA256_PADDER_STATUS_EN
            o_busy <= 1'b1;
`endif
          end
        end
        FILL: begin
          if (acc) begin
            bp  <= bp + 6'd1;
            len <= len + LEN_W'(8);
            if (bus.i_byte_last) begin
              n                <= {1'b0, bp} + 7'd1;
              st               <= PAD;
              bus.o_byte_ready <= 1'b0;
            end else if (bp == 6'd63) begin
              st                 <= EMIT;
              bus.o_byte_ready   <= 1'b0;
              bus.o_block_last   <= 1'b0;
              bus.o_padding_done <= 1'b1;
              bus.o_flag_0_15    <= 1'b0;
              bus.o_word_idx     <= 4'd0;
              bus.o_data         <= blk_n[511 -: 32];
            end
          end
        end
        PAD: begin
          needlen            <= (n > 7'd55);
          pend80             <= (n == 7'd64);
          bus.o_block_last   <= (n <= 7'd55);
          st                 <= EMIT;
          bus.o_padding_done <= 1'b1;
          bus.o_flag_0_15    <= 1'b0;
          bus.o_word_idx     <= 4'd0;
          bus.o_data         <= blk_n[511 -: 32];
        end
        EMIT: begin
          if (bus.o_word_idx == 4'd15) begin
            st              <= WAIT_ACK;
            bus.o_flag_0_15 <= 1'b1;
          end else begin
            bus.o_word_idx <= bus.o_word_idx + 4'd1;
            bus.o_data <=
              blk_n[511 - 32*(int'(bus.o_word_idx) + 1) -: 32];
          end
        end
        WAIT_ACK: begin
          if (bus.i_block_ack) begin
            st                 <= GAP;
            bus.o_padding_done <= 1'b0;
            bus.o_flag_0_15    <= 1'b0;
`ifdef SHA256_PADDER_STATUS_EN
            o_block_cnt <= o_block_cnt + 16'd1;
`endif
          end
        end
        GAP: begin
          if (needlen) begin
            needlen            <= 1'b0;
            pend80             <= 1'b0;
            bus.o_block_last   <= 1'b1;
            st                 <= EMIT;
            bus.o_padding_done <= 1'b1;
            bus.o_word_idx     <= 4'd0;
            bus.o_data         <= blk_n[511 -: 32];
          end else if (bus.o_block_last) begin
            len              <= '0;
            bp               <= '0;
            bus.o_block_last <= 1'b0;
            st               <= IDLE;
            bus.o_byte_ready <= 1'b1;
`ifdef SHA256_PADDER_STATUS_EN
            o_busy <= 1'b0;
`endif
          end else begin
            bp               <= '0;
            st               <= FILL;
            bus.o_byte_ready <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
